axis_video_pattern_gen: RTL and testbench

- AXI4-Stream video master that synthesises complete frames: test patterns, sized WIDTH×HEIGHT, with standard SOF/EOL sideband.
- It is the upstream transmitter that feeds barrel_distortion_correction in simulation and in on-board bring-up.
- Grid and colour-bar patterns make the geometric correction visible on a monitor or in a frame dump.
- Honours downstream backpressure exactly and inserts a programmable idle gap between frames.

---
 rtl/axis_video_pattern_gen.sv | 202 ++++++++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern master: solid, ramp, grid and colour-bar frames
// with SOF/EOL sideband, exact backpressure handling and an idle gap between frames.
module axis_video_pattern_gen #(
   parameter int unsigned WIDTH       = 1920,
   parameter int unsigned HEIGHT      = 1080,
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned COORD_WIDTH = 16,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned GRID_SHIFT  = 5,
   parameter logic [23:0] SOLID_COLOR = 24'h808080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            pattern_sel,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  frame_done,
   output logic [15:0]           frame_count
);

   localparam logic [COORD_WIDTH-1:0] X_LAST   = COORD_WIDTH'(WIDTH - 1);
   localparam logic [COORD_WIDTH-1:0] Y_LAST   = COORD_WIDTH'(HEIGHT - 1);
   localparam logic [COORD_WIDTH-1:0] BAR_LAST = COORD_WIDTH'(WIDTH / 8 - 1);
   localparam logic [15:0]            GAP_LIM  = 16'(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t                 state_q, state_d;
   logic [COORD_WIDTH-1:0] x_q, x_d;
   logic [COORD_WIDTH-1:0] y_q, y_d;
   logic [COORD_WIDTH-1:0] barcnt_q, barcnt_d;
   logic [2:0]             bar_q, bar_d;
   logic [15:0]            gap_q, gap_d;
   logic [1:0]             pat_q, pat_d;
   logic [23:0]            tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic                   tuser_q, tuser_d;
   logic                   frame_done_q, frame_done_d;
   logic [15:0]            frame_count_q, frame_count_d;
   logic                   start;
   logic                   load;
   logic                   grid_hit;
   logic [23:0]            pix;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         barcnt_q      <= '0;
         bar_q         <= '0;
         gap_q         <= '0;
         pat_q         <= '0;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         tuser_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         barcnt_q      <= barcnt_d;
         bar_q         <= bar_d;
         gap_q         <= gap_d;
         pat_q         <= pat_d;
         tdata_q       <= tdata_d;
         tvalid_q      <= tvalid_d;
         tlast_q       <= tlast_d;
         tuser_q       <= tuser_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Sequencing: decides the coordinates of the next presented pixel.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      barcnt_d      = barcnt_q;
      bar_d         = bar_q;
      gap_d         = gap_q;
      pat_d         = pat_q;
      tvalid_d      = tvalid_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      start         = 1'b0;
      load          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable) start = 1'b1;
         end
         S_ACTIVE: begin
            if (tvalid_q && m_axis_tready) begin
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  // The frame_done cycle is the first idle cycle of the gap.
                  state_d       = S_GAP;
                  gap_d         = 16'd1;
                  tvalid_d      = 1'b0;
                  frame_done_d  = 1'b1;
                  frame_count_d = frame_count_q + 1'b1;
               end else begin
                  load = 1'b1;
                  if (x_q == X_LAST) begin
                     x_d      = '0;
                     y_d      = y_q + 1'b1;
                     barcnt_d = '0;
                     bar_d    = '0;
                  end else begin
                     x_d = x_q + 1'b1;
                     if (barcnt_q == BAR_LAST) begin
                        barcnt_d = '0;
                        bar_d    = bar_q + 1'b1;
                     end else begin
                        barcnt_d = barcnt_q + 1'b1;
                     end
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_q >= GAP_LIM) begin
               if (enable) start = 1'b1;
               else        state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         state_d  = S_ACTIVE;
         pat_d    = pattern_sel;
         x_d      = '0;
         y_d      = '0;
         barcnt_d = '0;
         bar_d    = '0;
         gap_d    = '0;
         tvalid_d = 1'b1;
         load     = 1'b1;
      end
   end

   always_comb begin
      grid_hit = (x_d[GRID_SHIFT-1:0] == '0) || (y_d[GRID_SHIFT-1:0] == '0) ||
                 (x_d == X_LAST) || (y_d == Y_LAST);
      pix = SOLID_COLOR;
      unique case (pat_d)
         2'd0: pix = SOLID_COLOR;
         2'd1: pix = {x_d[7:0], y_d[7:0], x_d[7:0] + y_d[7:0]};
         2'd2: pix = grid_hit ? 24'hFFFFFF : 24'h000000;
         2'd3: begin
            unique case (bar_d)
               3'd0: pix = 24'hFFFFFF;
               3'd1: pix = 24'hFFFF00;
               3'd2: pix = 24'h00FFFF;
               3'd3: pix = 24'h00FF00;
               3'd4: pix = 24'hFF00FF;
               3'd5: pix = 24'hFF0000;
               3'd6: pix = 24'h0000FF;
               3'd7: pix = 24'h000000;
               default: pix = 24'h000000;
            endcase
         end
         default: pix = SOLID_COLOR;
      endcase
   end

   // Beat registers only move on a load, so they hold under backpressure.
   always_comb begin
      tdata_d = tdata_q;
      tlast_d = tlast_q;
      tuser_d = tuser_q;
      if (load) begin
         tdata_d = pix;
         tlast_d = (x_d == X_LAST);
         tuser_d = (x_d == '0) && (y_d == '0);
      end else if (frame_done_d) begin
         tlast_d = 1'b0;
         tuser_d = 1'b0;
      end
   end

   assign m_axis_tdata  = DATA_WIDTH'(tdata_q);
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign frame_done    = frame_done_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen on an 8x4 frame with a 3-cycle gap.
module tb_axis_video_pattern_gen;

   localparam int W   = 8;
   localparam int H   = 4;
   localparam int GAP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        m_axis_tready = 1'b1;
   logic        frame_done;
   logic [15:0] frame_count;

   axis_video_pattern_gen #(
      .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24), .COORD_WIDTH(16),
      .GAP_CYCLES(GAP), .GRID_SHIFT(2), .SOLID_COLOR(24'h808080)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .m_axis_tready(m_axis_tready), .frame_done(frame_done),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int          pass_cnt = 0;
   int          total = 0;
   logic [25:0] sb_q[$];
   int          beat_cnt = 0;
   int          fb = 0;
   int          low_run = 0;
   int          last_gap = -1;
   int          fd_cnt = 0;
   logic [23:0] cap21 = '0;
   bit          rand_rdy = 1'b0;
   bit          hold_chk = 1'b0;
   logic [25:0] h_beat;

   always @(posedge clk) begin
      #1;
      m_axis_tready <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   function automatic logic [23:0] exp_pix(input int pat, input int x, input int y);
      int s;
      s = x + y;
      case (pat)
         0: return 24'h808080;
         1: return {x[7:0], y[7:0], s[7:0]};
         2: return (x % 4 == 0 || y % 4 == 0 || x == W - 1 || y == H - 1) ?
                   24'hFFFFFF : 24'h000000;
         default: case (x / (W / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
         endcase
      endcase
   endfunction

   task automatic push_frame(input int pat);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            sb_q.push_back({exp_pix(pat, x, y), x == W - 1, x == 0 && y == 0});
   endtask

   always @(negedge clk) begin
      if (rst) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            total++;
            if (!m_axis_tvalid ||
                {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== h_beat)
               $display("FAIL hold: got v=%0b %h req v=1 %h", m_axis_tvalid,
                        {m_axis_tdata, m_axis_tlast, m_axis_tuser}, h_beat);
            else pass_cnt++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            total++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_underflow: got beat %h req none",
                        {m_axis_tdata, m_axis_tlast, m_axis_tuser});
            end else begin
               logic [25:0] e;
               e = sb_q.pop_front();
               if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e)
                  $display("FAIL beat %0d: got %h req %h", fb,
                           {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
               else pass_cnt++;
            end
            if (m_axis_tuser) begin
               last_gap = low_run;
               fb = 0;
            end else begin
               fb++;
            end
            if (fb == 21) cap21 = m_axis_tdata;
            low_run = 0;
            beat_cnt++;
         end else if (!m_axis_tvalid) begin
            low_run++;
         end
         if (frame_done) fd_cnt++;
         hold_chk = m_axis_tvalid && !m_axis_tready;
         h_beat = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      end
   end

   task automatic wait_beats(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (beat_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_empty(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic settle();
      repeat (GAP + 4) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done} !== 4'b0 ||
          m_axis_tdata !== 24'h0 || frame_count !== 16'h0)
         $display("FAIL reset_outputs: got v%0b l%0b u%0b fd%0b d%h fc%0d req all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done,
                  m_axis_tdata, frame_count);
      else pass_cnt++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_bars();
      bit ok;
      int fd0;
      fd0 = fd_cnt;
      push_frame(3);
      pattern_sel = 2'd3;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1)
         $display("FAIL start_latency: got v%0b u%0b req v1 u1",
                  m_axis_tvalid, m_axis_tuser);
      else pass_cnt++;
      wait_empty(200, ok);
      total++;
      if (!ok) $display("FAIL bars_timeout: got %0d left req 0", sb_q.size());
      else pass_cnt++;
      settle();
      total++;
      if (fd_cnt - fd0 !== 1 || frame_count !== 16'd1)
         $display("FAIL bars_done: got fd%0d fc%0d req fd1 fc1",
                  fd_cnt - fd0, frame_count);
      else pass_cnt++;
   endtask

   task automatic test_gap();
      bit ok;
      int s;
      s = beat_cnt;
      push_frame(3);
      push_frame(3);
      enable = 1'b1;
      wait_beats(s + W * H + 1, 300, ok);
      enable = 1'b0;
      total++;
      if (!ok || last_gap !== GAP)
         $display("FAIL gap_len: got %0d (ok=%0b) req %0d", last_gap, ok, GAP);
      else pass_cnt++;
      wait_empty(300, ok);
      settle();
      total++;
      if (!ok || frame_count !== 16'd3)
         $display("FAIL gap_count: got fc%0d ok=%0b req fc3", frame_count, ok);
      else pass_cnt++;
   endtask

   task automatic test_ramp_bp();
      bit ok;
      push_frame(1);
      rand_rdy = 1'b1;
      pattern_sel = 2'd1;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_empty(1000, ok);
      rand_rdy = 1'b0;
      settle();
      total++;
      if (!ok || cap21 !== 24'h050207)
         $display("FAIL ramp_x5y2: got %h ok=%0b req 050207", cap21, ok);
      else pass_cnt++;
      total++;
      if (frame_count !== 16'd4)
         $display("FAIL ramp_count: got %0d req 4", frame_count);
      else pass_cnt++;
   endtask

   task automatic test_grid_switch();
      bit ok;
      int s;
      s = beat_cnt;
      push_frame(2);
      push_frame(0);
      pattern_sel = 2'd2;
      enable = 1'b1;
      wait_beats(s + 5, 100, ok);
      pattern_sel = 2'd0;
      wait_beats(s + W * H + 1, 300, ok);
      enable = 1'b0;
      wait_empty(300, ok);
      settle();
      total++;
      if (!ok || frame_count !== 16'd6)
         $display("FAIL grid_switch: got fc%0d ok=%0b req fc6", frame_count, ok);
      else pass_cnt++;
   endtask

   task automatic test_enable_drop();
      bit ok;
      int s;
      int fd0;
      int hi;
      s = beat_cnt;
      fd0 = fd_cnt;
      push_frame(1);
      pattern_sel = 2'd1;
      enable = 1'b1;
      wait_beats(s + 10, 100, ok);
      enable = 1'b0;
      wait_empty(300, ok);
      total++;
      if (!ok || beat_cnt - s !== W * H)
         $display("FAIL drop_complete: got %0d beats req %0d", beat_cnt - s, W * H);
      else pass_cnt++;
      hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (m_axis_tvalid) hi++;
      end
      total++;
      if (hi !== 0 || fd_cnt - fd0 !== 1)
         $display("FAIL drop_idle: got valid%0d fd%0d req valid0 fd1",
                  hi, fd_cnt - fd0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int s;
      int fd0;
      int bad;
      s = beat_cnt;
      push_frame(0);
      pattern_sel = 2'd0;
      enable = 1'b1;
      wait_beats(s + 20, 100, ok);
      rst = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      sb_q.delete();
      total++;
      if (!ok || m_axis_tvalid !== 1'b0 || frame_count !== 16'd0 ||
          frame_done !== 1'b0)
         $display("FAIL reset_mid: got v%0b fc%0d fd%0b ok=%0b req v0 fc0 fd0",
                  m_axis_tvalid, frame_count, frame_done, ok);
      else pass_cnt++;
      rst = 1'b0;
      fd0 = fd_cnt;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_axis_tvalid || m_axis_tlast || frame_done) bad++;
      end
      total++;
      if (bad !== 0 || fd_cnt !== fd0)
         $display("FAIL reset_truncate: got %0d stray req 0", bad);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_bars();
      test_gap();
      test_ramp_bp();
      test_grid_switch();
      test_enable_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
